id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline. Sits directly downstream of the instruction decoder/controller.
- Latches decoded control points, operands and register indices into the EX stage and resolves the EX destination register.
- Detects load-use hazards and inserts bubbles. Runs a syscall halt/drain state machine.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipe_reg.sv | 171 +++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches decoded control and operands into EX,
// inserts load-use bubbles, runs the syscall drain/halt FSM and counts bubbles.
module id_ex_pipe_reg #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              resume,
    input  logic [19:0]       id_ctrl,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [4:0]        id_shamt,
    output logic [19:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [4:0]        ex_shamt,
    output logic              ex_valid,
    output logic              id_stall,
    output logic              halted,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int CTRL_MEM_TO_REG = 17;
    localparam int CTRL_REG_WRITE  = 10;
    localparam int CTRL_REG_DST    = 9;
    localparam int CTRL_JAL        = 8;
    localparam int CTRL_SYSCALL    = 3;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           state_reg;
    logic [DCW-1:0]   drain_cnt_reg;

    logic             load_use;
    logic             sys_in_ex;
    logic             stop;
    logic             load_bubble;
    logic             capture;
    logic             count_bubble;
    logic [REG_AW-1:0] wreg_next;

    always_comb begin
        load_use = ex_valid & ex_ctrl[CTRL_MEM_TO_REG] & (ex_wreg != '0) &
                   ((id_uses_rs & (ex_wreg == id_rs)) | (id_uses_rt & (ex_wreg == id_rt)));
        // A syscall sitting in EX already freezes the front end, so the
        // instructions behind it become drain bubbles from the next edge.
        sys_in_ex    = ex_valid & ex_ctrl[CTRL_SYSCALL];
        stop         = (state_reg != ST_RUN) | sys_in_ex;
        id_stall     = load_use | ex_hold | stop;
        load_bubble  = flush | (!ex_hold & (stop | load_use));
        capture      = !flush & !ex_hold & !stop & !load_use;
        count_bubble = flush | (!ex_hold & !stop & load_use);
    end

    always_comb begin
        if (id_ctrl[CTRL_JAL])
            wreg_next = REG_AW'(31);
        else if (!id_ctrl[CTRL_REG_WRITE])
            wreg_next = '0;
        else if (id_ctrl[CTRL_REG_DST])
            wreg_next = id_rd;
        else
            wreg_next = id_rt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl    <= '0;
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            ex_shamt   <= '0;
            ex_valid   <= 1'b0;
        end else if (load_bubble) begin
            ex_ctrl    <= '0;
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            ex_shamt   <= '0;
            ex_valid   <= 1'b0;
        end else if (capture) begin
            ex_ctrl    <= id_ctrl;
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wreg    <= wreg_next;
            ex_shamt   <= id_shamt;
            ex_valid   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (count_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            drain_cnt_reg <= '0;
            halted        <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (sys_in_ex && !ex_hold && !flush) begin
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    // MEM/WB only advance while EX is not held
                    if (!ex_hold) begin
                        if (drain_cnt_reg == '0) begin
                            state_reg <= ST_HALTED;
                            halted    <= 1'b1;
                        end else begin
                            drain_cnt_reg <= drain_cnt_reg - 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_reg <= ST_RUN;
                        halted    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table through a scoreboard queue, plus
// hand sequences for hold, syscall drain/resume, async reset and saturation.
module tb_id_ex_pipe_reg;

    localparam logic [19:0] MTR = 20'd1 << 17;
    localparam logic [19:0] MW  = 20'd1 << 16;
    localparam logic [19:0] RW  = 20'd1 << 10;
    localparam logic [19:0] RD  = 20'd1 << 9;
    localparam logic [19:0] JAL = 20'd1 << 8;
    localparam logic [19:0] SYS = 20'd1 << 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, ex_hold = 1'b0, resume = 1'b0;
    logic [19:0] id_ctrl = '0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic [31:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
    logic [19:0] ex_ctrl;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wreg, ex_shamt;
    logic        ex_valid, id_stall, halted;
    logic [3:0]  bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .DRAIN_CYCLES(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_hold(ex_hold), .resume(resume),
        .id_ctrl(id_ctrl), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_shamt(ex_shamt),
        .ex_valid(ex_valid), .id_stall(id_stall), .halted(halted), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic [19:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic        urs, urt, fl, hd;
        logic        exp_stall, exp_valid;
        logic [4:0]  exp_wreg;
        logic [3:0]  exp_cnt;
    } vec_t;

    typedef struct {
        string       tag;
        logic        valid;
        logic [4:0]  wreg;
        logic [19:0] ctrl;
        logic [31:0] rsd;
        logic [3:0]  cnt;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    function automatic vec_t mk(logic [19:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic urs, logic urt, logic fl, logic hd, logic es, logic ev,
                                logic [4:0] ew, logic [3:0] ec);
        vec_t v;
        v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd;
        v.urs = urs; v.urt = urt; v.fl = fl; v.hd = hd;
        v.exp_stall = es; v.exp_valid = ev; v.exp_wreg = ew; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic v, input logic [4:0] w,
                        input logic [19:0] c, input logic [31:0] rsd, input logic [3:0] cnt);
        exp_t e;
        e.tag = tag; e.valid = v; e.wreg = w; e.ctrl = c; e.rsd = rsd; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
        check({e.tag, "_wreg"}, {27'd0, ex_wreg}, {27'd0, e.wreg});
        check({e.tag, "_ctrl"}, {12'd0, ex_ctrl}, {12'd0, e.ctrl});
        check({e.tag, "_rsd"}, ex_rs_data, e.rsd);
        check({e.tag, "_cnt"}, {28'd0, bubble_cnt}, {28'd0, e.cnt});
        $display("txn %s valid=%0b wreg=%0d cnt=%0d stall=%0b halted=%0b",
                 e.tag, ex_valid, ex_wreg, bubble_cnt, id_stall, halted);
    endtask

    task automatic set_in(input logic [19:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic [31:0] rsd);
        id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_rs_data = rsd; id_rt_data = ~rsd; id_imm = rsd ^ 32'h5555_5555;
        id_pc4 = rsd + 32'd4; id_shamt = rsd[4:0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_cnt;
        logic [31:0] rsd;

        vecs[0]  = mk(RW | RD,  5'd1, 5'd2,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  4'd0);
        vecs[1]  = mk(RW,       5'd3, 5'd9,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  4'd0);
        vecs[2]  = mk(JAL,      5'd0, 5'd6,  5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 4'd0);
        vecs[3]  = mk(MW,       5'd2, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  4'd0);
        vecs[4]  = mk(MTR | RW, 5'd1, 5'd0,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  4'd0);
        vecs[5]  = mk(RW | RD,  5'd0, 5'd0,  5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 4'd0);
        vecs[6]  = mk(MTR | RW, 5'd1, 5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  4'd0);
        vecs[7]  = mk(RW | RD,  5'd8, 5'd2,  5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  4'd1);
        vecs[8]  = mk(RW | RD,  5'd8, 5'd2,  5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 4'd1);
        vecs[9]  = mk(MTR | RW, 5'd1, 5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  4'd1);
        vecs[10] = mk(RW | RD,  5'd4, 5'd8,  5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  4'd2);
        vecs[11] = mk(RW | RD,  5'd1, 5'd2,  5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  4'd3);
        vecs[12] = mk(RW | RD,  5'd1, 5'd2,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  4'd3);

        // reset state
        #3;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ctrl", {12'd0, ex_ctrl}, 32'd0);
        check("rst_stall", {31'd0, id_stall}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cnt", {28'd0, bubble_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rsd = 32'hA000_0000 + 32'(i);
            set_in(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].urs, vecs[i].urt, rsd);
            flush = vecs[i].fl;
            ex_hold = vecs[i].hd;
            #1;
            check($sformatf("v%0d_stall", i), {31'd0, id_stall}, {31'd0, vecs[i].exp_stall});
            push($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_wreg,
                 vecs[i].exp_valid ? vecs[i].ctrl : 20'd0,
                 vecs[i].exp_valid ? rsd : 32'd0, vecs[i].exp_cnt);
            @(posedge clk);
            #1;
            pop_compare();
        end

        // ex_hold alone for 3 cycles: EX keeps v12
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            flush = 1'b0;
            ex_hold = 1'b1;
            set_in(RW, 5'd3, 5'd20, 5'd21, 1'b0, 1'b0, 32'hB000_0000 + 32'(k));
            #1;
            check($sformatf("hold%0d_stall", k), {31'd0, id_stall}, 32'd1);
            push($sformatf("hold%0d", k), 1'b1, 5'd5, RW | RD, 32'hA000_000C, 4'd3);
            @(posedge clk);
            #1;
            pop_compare();
        end
        @(negedge clk);
        ex_hold = 1'b0;
        push("post_hold", 1'b1, 5'd20, RW, 32'hB000_0002, 4'd3);
        @(posedge clk);
        #1;
        pop_compare();

        // syscall drain and resume
        @(negedge clk);
        set_in(SYS, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 32'hC000_0000);
        #1;
        check("sys_stall_pre", {31'd0, id_stall}, 32'd0);
        push("sys_cap", 1'b1, 5'd0, SYS, 32'hC000_0000, 4'd3);
        @(posedge clk);
        #1;
        pop_compare();
        check("sys_stall_n", {31'd0, id_stall}, 32'd1);
        check("sys_halt_n", {31'd0, halted}, 32'd0);
        @(negedge clk);
        set_in(RW | RD, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 32'hD000_0000);
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("drain%0d", k), 1'b0, 5'd0, 20'd0, 32'd0, 4'd3);
            @(posedge clk);
            #1;
            pop_compare();
            check($sformatf("drain%0d_halted", k), {31'd0, halted}, 32'd0);
            check($sformatf("drain%0d_stall", k), {31'd0, id_stall}, 32'd1);
        end
        @(posedge clk);
        #1;
        check("halt_n4", {31'd0, halted}, 32'd1);
        check("halt_n4_valid", {31'd0, ex_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("halt_stays", {31'd0, halted}, 32'd1);
        check("halt_stall", {31'd0, id_stall}, 32'd1);
        @(negedge clk);
        resume = 1'b1;
        @(posedge clk);
        #1;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_valid", {31'd0, ex_valid}, 32'd0);
        @(negedge clk);
        resume = 1'b0;
        #1;
        check("resume_stall", {31'd0, id_stall}, 32'd0);
        push("post_resume", 1'b1, 5'd7, RW | RD, 32'hD000_0000, 4'd3);
        @(posedge clk);
        #1;
        pop_compare();

        // async reset in the middle of a drain
        @(negedge clk);
        set_in(SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hE000_0000);
        @(posedge clk);
        #1;
        check("rst2_sys_valid", {31'd0, ex_valid}, 32'd1);
        @(negedge clk);
        set_in(RW | RD, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 32'hE000_0001);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_valid", {31'd0, ex_valid}, 32'd0);
        check("rst2_cnt", {28'd0, bubble_cnt}, 32'd0);
        check("rst2_stall", {31'd0, id_stall}, 32'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst2_run_stall", {31'd0, id_stall}, 32'd0);
        push("rst2_cap", 1'b1, 5'd9, RW | RD, 32'hE000_0001, 4'd0);
        @(posedge clk);
        #1;
        pop_compare();
        repeat (4) @(posedge clk);
        #1;
        check("rst2_no_halt", {31'd0, halted}, 32'd0);

        // saturation: 20 flushes on a 4-bit counter
        exp_cnt = 4'd0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            flush = 1'b1;
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            push($sformatf("sat%0d", k), 1'b0, 5'd0, 20'd0, 32'd0, exp_cnt);
            @(posedge clk);
            #1;
            pop_compare();
        end
        check("sat_final", {28'd0, bubble_cnt}, 32'd15);
        @(negedge clk);
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
